// File: rtl/ssd_scan_ctrl_if.sv
// Display-word and board-pin bundle for the seven-segment scanner.
// master = datapath building the display word, slave = scanner driving AN/SD.
interface ssd_scan_ctrl_if #(
  parameter int DIGITS   = 8,
  parameter int PWM_BITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  enable;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blank_mask;
  logic [PWM_BITS-1:0]   brightness;
  logic [DIGITS-1:0]     an;
  logic [7:0]            seg;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_start;

  modport master (
    output enable, data, dp_mask, blank_mask, brightness,
    input  an, seg, digit_idx, frame_start
  );

  modport slave (
    input  enable, data, dp_mask, blank_mask, brightness,
    output an, seg, digit_idx, frame_start
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan scheduler: dead-time + PWM per digit, frame-shadowed inputs.
// Outputs registered (decision in cycle N on pins in N+1); no backpressure, free-running scan.
module ssd_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int DIGIT_CYCLES = 12500,
  parameter int BLANK_CYCLES = 100,
  parameter int PWM_BITS     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ssd_scan_ctrl_if.slave bus
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      blank;
    logic [PWM_BITS-1:0]    bright;
  } shadow_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  shadow_t             shadow_q, shadow_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_start_q, frame_start_d;
  logic                capture;

  // Active-low {dp, g..a} with dp off.
  function automatic logic [7:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 8'hC0;
      4'h1: hex_decode = 8'hF9;
      4'h2: hex_decode = 8'hA4;
      4'h3: hex_decode = 8'hB0;
      4'h4: hex_decode = 8'h99;
      4'h5: hex_decode = 8'h92;
      4'h6: hex_decode = 8'h82;
      4'h7: hex_decode = 8'hF8;
      4'h8: hex_decode = 8'h80;
      4'h9: hex_decode = 8'h90;
      4'hA: hex_decode = 8'h88;
      4'hB: hex_decode = 8'h83;
      4'hC: hex_decode = 8'hC6;
      4'hD: hex_decode = 8'hA1;
      4'hE: hex_decode = 8'h86;
      default: hex_decode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    pwm_d         = pwm_q;
    shadow_d      = shadow_q;
    capture       = 1'b0;
    an_d          = '1;
    seg_d         = 8'hFF;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          capture = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
            pwm_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          pwm_d = pwm_q + 1'b1;
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              capture = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Shadow load coincides with the frame_start edge so a frame never mixes old/new inputs.
    if (capture) begin
      shadow_d.nib    = bus.data;
      shadow_d.dp     = bus.dp_mask;
      shadow_d.blank  = bus.blank_mask;
      shadow_d.bright = bus.brightness;
    end
    frame_start_d = capture;

    // Pins follow the next state so they line up with the state register.
    if (state_d == DRIVE) begin
      seg_d = hex_decode(shadow_q.nib[idx_d]) & {~shadow_q.dp[idx_d], 7'h7F};
      if (!shadow_q.blank[idx_d] &&
          ((&shadow_q.bright) || (pwm_d < shadow_q.bright))) begin
        an_d[idx_d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      shadow_q      <= '0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      shadow_q      <= shadow_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = frame_start_q;

endmodule
